// File: rtl/seg_scan_6digit.sv
// Six-digit common-anode 7-segment scanner: frame-latched BCD digits, dead-time ghost suppression, blinking colon.
// Outputs registered (1-cycle latency from scan state); no backpressure, free-running scan.
module seg_scan_6digit #(
  parameter int SCAN_CNT  = 50_000,
  parameter int DEAD      = 2,
  parameter int BLINK_CNT = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] hour_t,
  input  logic [3:0] hour_o,
  input  logic [2:0] min_t,
  input  logic [3:0] min_o,
  input  logic [2:0] sec_t,
  input  logic [3:0] sec_o,
  input  logic       lz_blank,
  output logic [7:0] seg_n,
  output logic [5:0] sel_n,
  output logic       frame_start
);

  localparam int SW = $clog2(SCAN_CNT);
  localparam int BW = $clog2(BLINK_CNT + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CNT - 1);
  localparam logic [SW-1:0] DEAD_V     = SW'(DEAD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

  logic [SW-1:0]     scan_cnt;
  logic [2:0]        idx;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic [5:0][3:0]   shadow;
  logic              scan_wrap;
  logic              blink_wrap;
  logic              frame_end;
  logic              dead;
  logic [3:0]        digit;
  logic [7:0]        seg_nxt;
  logic [5:0]        sel_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  assign frame_end  = scan_wrap && (idx == 3'd5);
  assign dead       = (scan_cnt < DEAD_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) phase <= ~phase;
    end
  end

  // Digits are captured only at the frame boundary so a frame never mixes two times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      if (frame_end)
        shadow <= {sec_o, {1'b0, sec_t}, min_o, {1'b0, min_t}, hour_o, {2'b00, hour_t}};
      frame_start <= frame_end;
    end
  end

  always_comb begin
    case (idx)
      3'd0:    digit = shadow[0];
      3'd1:    digit = shadow[1];
      3'd2:    digit = shadow[2];
      3'd3:    digit = shadow[3];
      3'd4:    digit = shadow[4];
      default: digit = shadow[5];
    endcase
  end

  always_comb begin
    sel_nxt = 6'h3F;
    seg_nxt = 8'hFF;
    if (!dead) begin
      sel_nxt = ~(6'd1 << idx);
      seg_nxt = {~(phase && (idx == 3'd1 || idx == 3'd3)), seg_decode(digit)};
      // lz_blank is live; the digit select stays on so scan timing is unchanged.
      if (lz_blank && idx == 3'd0 && shadow[0] == 4'd0) seg_nxt = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 8'hFF;
      sel_n <= 6'h3F;
    end else begin
      seg_n <= seg_nxt;
      sel_n <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_6digit.sv
// Bench for seg_scan_6digit: table vectors, hand sequences and randomized inputs against a cycle-count model.
module tb_seg_scan_6digit;

  localparam int SCAN  = 4;
  localparam int DEAD  = 1;
  localparam int BLINK = 8;
  localparam int FRAME = 6 * SCAN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] hour_t;
  logic [3:0] hour_o;
  logic [2:0] min_t;
  logic [3:0] min_o;
  logic [2:0] sec_t;
  logic [3:0] sec_o;
  logic       lz_blank;
  logic [7:0] seg_n;
  logic [5:0] sel_n;
  logic       frame_start;

  always #5 clk = ~clk;

  seg_scan_6digit #(.SCAN_CNT(SCAN), .DEAD(DEAD), .BLINK_CNT(BLINK)) dut (
    .clk(clk), .rst_n(rst_n),
    .hour_t(hour_t), .hour_o(hour_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o), .lz_blank(lz_blank),
    .seg_n(seg_n), .sel_n(sel_n), .frame_start(frame_start)
  );

  typedef struct {
    logic [1:0]      ht;
    logic [3:0]      ho;
    logic [2:0]      mt;
    logic [3:0]      mo;
    logic [2:0]      st;
    logic [3:0]      so;
    logic            lz;
    logic [5:0][6:0] exp_code;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int k;
  int fs_cnt;
  logic [3:0] sh [6];
  logic [6:0] code [16];
  logic [5:0] sel_exp [6];
  vec_t vecs [5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] ht, input logic [3:0] ho, input logic [2:0] mt,
                        input logic [3:0] mo, input logic [2:0] st, input logic [3:0] so,
                        input logic lz);
    hour_t = ht; hour_o = ho; min_t = mt; min_o = mo; sec_t = st; sec_o = so; lz_blank = lz;
  endtask

  // One clock: predict from cycle count k since reset and the model's shadow, then compare.
  task automatic step();
    logic [3:0] in_d [6];
    logic       lz;
    int         sc, ix, ph;
    logic [7:0] es;
    logic [5:0] esel;
    logic       efs;
    in_d[0] = {2'b00, hour_t}; in_d[1] = hour_o; in_d[2] = {1'b0, min_t};
    in_d[3] = min_o;           in_d[4] = {1'b0, sec_t}; in_d[5] = sec_o;
    lz = lz_blank;
    sc = k % SCAN;
    ix = (k / SCAN) % 6;
    ph = (k / BLINK) % 2;
    if (sc < DEAD) begin
      esel = 6'h3F;
      es   = 8'hFF;
    end else begin
      esel = 6'h3F ^ (6'd1 << ix);
      es   = {!(ph == 1 && (ix == 1 || ix == 3)), code[sh[ix]]};
      if (lz && ix == 0 && sh[0] == 4'd0) es = 8'hFF;
    end
    efs = (k % FRAME == FRAME - 1);
    @(posedge clk);
    #1;
    chk("sel_n", 16'(sel_n), 16'(esel));
    chk("seg_n", 16'(seg_n), 16'(es));
    chk("frame_start", 16'(frame_start), 16'(efs));
    if (frame_start) fs_cnt++;
    if (efs) for (int i = 0; i < 6; i++) sh[i] = in_d[i];
    k++;
  endtask

  task automatic sync_frame();
    step();
    while (k % FRAME != 0) step();
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 6; i++) sh[i] = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d timeout reached", k);
    $fatal(1, "timeout");
  end

  initial begin
    code = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    sel_exp = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    vecs[0] = '{2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 1'b0,
                {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}};
    vecs[1] = '{2'd0, 4'd8, 3'd4, 4'd5, 3'd0, 4'd9, 1'b1,
                {7'h10, 7'h40, 7'h12, 7'h19, 7'h00, 7'h7F}};
    vecs[2] = '{2'd0, 4'd8, 3'd4, 4'd5, 3'd0, 4'd9, 1'b0,
                {7'h10, 7'h40, 7'h12, 7'h19, 7'h00, 7'h40}};
    vecs[3] = '{2'd2, 4'hC, 3'd7, 4'd9, 3'd3, 4'hF, 1'b0,
                {7'h3F, 7'h30, 7'h10, 7'h78, 7'h3F, 7'h24}};
    vecs[4] = '{2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd7, 1'b1,
                {7'h78, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F}};
    fs_cnt = 0;
    model_reset();

    // Power-on reset
    rst_n = 1'b0;
    set_in(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 1'b0);
    #12;
    chk("rst_sel_n", 16'(sel_n), 16'h3F);
    chk("rst_seg_n", 16'(seg_n), 16'hFF);
    chk("rst_frame_start", 16'(frame_start), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame shows zeros although inputs already hold 12:34:56
    for (int i = 0; i < 8; i++) step();
    chk("frame1_idx1_seg", 16'(seg_n[6:0]), 16'h40);

    // Table vectors: inputs latched at a boundary, checked over the following frame
    for (int v = 0; v < 5; v++) begin
      set_in(vecs[v].ht, vecs[v].ho, vecs[v].mt, vecs[v].mo, vecs[v].st, vecs[v].so, vecs[v].lz);
      sync_frame();
      for (int s = 0; s < 6; s++) begin
        for (int c = 0; c < SCAN; c++) begin
          step();
          if (c >= DEAD) begin
            chk("tbl_sel_n", 16'(sel_n), 16'(sel_exp[s]));
            chk("tbl_seg_code", 16'(seg_n[6:0]), 16'(vecs[v].exp_code[s]));
          end
        end
      end
    end

    // Mid-frame input change must not tear the current frame
    set_in(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 1'b0);
    sync_frame();
    for (int i = 0; i < 12; i++) step();
    sec_o = 4'd7;
    while (k % FRAME != 0) step();
    chk("sec_o_held", 16'(seg_n[6:0]), 16'h02);
    fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) step();
    chk("sec_o_updated", 16'(seg_n[6:0]), 16'h78);
    for (int i = 0; i < FRAME; i++) step();
    chk("frame_start_count", 16'(fs_cnt), 16'd2);

    // Asynchronous reset in the middle of a slot
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel_n", 16'(sel_n), 16'h3F);
    chk("arst_seg_n", 16'(seg_n), 16'hFF);
    chk("arst_frame_start", 16'(frame_start), 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step();
    chk("post_rst_idx1_seg", 16'(seg_n[6:0]), 16'h40);

    // Randomized inputs, including non-BCD values, changing at arbitrary cycles
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_in(2'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 3'($urandom),
               4'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) hour_t = 2'd0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
